// File: rtl/adxl362_spi_responder.sv
// ADXL362 register-map emulator on the responder side of a mode-0 SPI bus.
// Lets the ACL2 SPI initiator run in loopback without the real sensor.
//
// Ports
//   i_clk_20mhz, i_rst_20mhz_n     : system clock, async active-low reset
//   ei_sck, ei_csn, ei_copi        : SPI pins from the initiator (asynchronous)
//   eo_cipo_o, eo_cipo_t           : CIPO data and tri-state enable (1 = high-Z)
//   eo_int1, eo_int2               : interrupt levels from STATUS and INTMAP1/2
//   i_meas_data, i_meas_valid      : new XDATA_L..TEMP_H bytes (0x0E..0x15)
//   i_act_pulse, i_inact_pulse     : set STATUS.ACT / STATUS.INACT
//   o_reg_power_ctl                : current POWER_CTL (0x2D)
//   o_transact_done, o_soft_reset  : one-cycle pulses at the end of a transaction
module adxl362_spi_responder #(
  parameter logic [7:0] parm_part_id = 8'hF2,
  parameter logic [7:0] parm_rev_id  = 8'h01
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rst_20mhz_n,
  input  logic        ei_sck,
  input  logic        ei_csn,
  input  logic        ei_copi,
  output logic        eo_cipo_o,
  output logic        eo_cipo_t,
  output logic        eo_int1,
  output logic        eo_int2,
  input  logic [63:0] i_meas_data,
  input  logic        i_meas_valid,
  input  logic        i_act_pulse,
  input  logic        i_inact_pulse,
  output logic [7:0]  o_reg_power_ctl,
  output logic        o_transact_done,
  output logic        o_soft_reset
);

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_WRITE, ST_READ, ST_IGNORE} state_e;

  localparam int unsigned FILTER_IDX = 12;  // 0x2C
  localparam int unsigned INTMAP1_IDX = 10; // 0x2A
  localparam int unsigned INTMAP2_IDX = 11; // 0x2B
  localparam int unsigned POWER_IDX = 13;   // 0x2D

  // Reset: asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
    if (!i_rst_20mhz_n) rst_sync_q <= 2'b00;
    else                rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Two sync flops per pin, plus a third for edge detection on SCK/CSN.
  logic [2:0] sck_q, csn_q;
  logic [1:0] copi_q;
  always_ff @(posedge i_clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      sck_q  <= 3'b000;
      csn_q  <= 3'b111;
      copi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], ei_sck};
      csn_q  <= {csn_q[1:0], ei_csn};
      copi_q <= {copi_q[0], ei_copi};
    end
  end

  logic sck_rise, sck_fall, csn_rise, csn_fall;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign csn_rise = csn_q[1] & ~csn_q[2];
  assign csn_fall = ~csn_q[1] & csn_q[2];

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic        cmd_wr_q;
  logic [7:0]  addr_q, rd_addr_q, tx_q;
  logic        cipo_q;
  logic [7:0]  byte_in, rd_sel, rd_data;
  logic        byte_done, wr_done, rd_done;

  logic [7:0]  cfg_q [15];
  logic [63:0] meas_q, pend_q;
  logic        pend_v_q, dr_q, act_q, inact_q, soft_arm_q;
  logic        done_q, soft_q, int1_q, int2_q;
  logic [6:0]  status_w;

  assign byte_in   = {shift_q, copi_q[1]};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7) && (state_q != ST_IDLE);
  assign wr_done   = byte_done && (state_q == ST_WRITE);
  assign rd_done   = byte_done && (state_q == ST_READ);
  assign status_w  = {1'b0, inact_q, act_q, 3'b000, dr_q};

  // FSM state register
  always_ff @(posedge i_clk_20mhz or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (csn_fall) state_d = ST_CMD;
      ST_CMD:  if (byte_done) state_d = (byte_in == 8'h0A || byte_in == 8'h0B) ? ST_ADDR : ST_IGNORE;
      ST_ADDR: if (byte_done) state_d = cmd_wr_q ? ST_WRITE : ST_READ;
      default: state_d = state_q;
    endcase
    if (csn_rise) state_d = ST_IDLE;
  end

  // FSM outputs: CIPO is driven only during a read data phase or an ignored command.
  always_comb begin
    eo_cipo_t = 1'b1;
    if (!csn_q[1] && (state_q == ST_READ || state_q == ST_IGNORE)) eo_cipo_t = 1'b0;
  end

  // During the address byte the register is fetched from the incoming byte itself.
  assign rd_sel = (state_q == ST_ADDR) ? byte_in : addr_q;

  always_comb begin
    rd_data = 8'h00;
    case (rd_sel)
      8'h00: rd_data = 8'hAD;
      8'h01: rd_data = 8'h1D;
      8'h02: rd_data = parm_part_id;
      8'h03: rd_data = parm_rev_id;
      8'h0B: rd_data = {1'b0, status_w};
      8'h0E: rd_data = meas_q[63:56];
      8'h0F: rd_data = meas_q[55:48];
      8'h10: rd_data = meas_q[47:40];
      8'h11: rd_data = meas_q[39:32];
      8'h12: rd_data = meas_q[31:24];
      8'h13: rd_data = meas_q[23:16];
      8'h14: rd_data = meas_q[15:8];
      8'h15: rd_data = meas_q[7:0];
      default: if (rd_sel inside {[8'h20:8'h2E]}) rd_data = cfg_q[rd_sel[3:0]];
    endcase
  end

  // Bit/byte datapath
  always_ff @(posedge i_clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= 3'd0;
      shift_q   <= 7'd0;
      cmd_wr_q  <= 1'b0;
      addr_q    <= 8'h00;
      rd_addr_q <= 8'h00;
      tx_q      <= 8'h00;
      cipo_q    <= 1'b0;
    end else if (csn_fall || csn_rise) begin
      bit_cnt_q <= 3'd0;
      tx_q      <= 8'h00;
      cipo_q    <= 1'b0;
    end else if (sck_rise && state_q != ST_IDLE) begin
      bit_cnt_q <= bit_cnt_q + 3'd1;
      shift_q   <= byte_in[6:0];
      if (bit_cnt_q == 3'd7) begin
        case (state_q)
          ST_CMD: begin
            cmd_wr_q <= (byte_in == 8'h0A);
            tx_q     <= 8'h00;
          end
          ST_ADDR: begin
            if (cmd_wr_q) begin
              addr_q <= byte_in;
            end else begin
              tx_q      <= rd_data;
              rd_addr_q <= byte_in;
              addr_q    <= byte_in + 8'd1;
            end
          end
          ST_WRITE: addr_q <= addr_q + 8'd1;
          ST_READ: begin
            tx_q      <= rd_data;
            rd_addr_q <= addr_q;
            addr_q    <= addr_q + 8'd1;
          end
          default: tx_q <= 8'h00;
        endcase
      end
    end else if (sck_fall && state_q != ST_IDLE) begin
      cipo_q <= tx_q[7];
      tx_q   <= {tx_q[6:0], 1'b0};
    end
  end

  // Register file, status and measurement shadow. Later assignments win, so
  // set pulses override same-cycle clears and soft reset overrides everything.
  always_ff @(posedge i_clk_20mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) cfg_q[i] <= (i == FILTER_IDX) ? 8'h13 : 8'h00;
      meas_q     <= 64'd0;
      pend_q     <= 64'd0;
      pend_v_q   <= 1'b0;
      dr_q       <= 1'b0;
      act_q      <= 1'b0;
      inact_q    <= 1'b0;
      soft_arm_q <= 1'b0;
      done_q     <= 1'b0;
      soft_q     <= 1'b0;
      int1_q     <= 1'b0;
      int2_q     <= 1'b0;
    end else begin
      done_q <= csn_rise;
      soft_q <= csn_rise & soft_arm_q;
      int1_q <= (|(status_w & cfg_q[INTMAP1_IDX][6:0])) ^ cfg_q[INTMAP1_IDX][7];
      int2_q <= (|(status_w & cfg_q[INTMAP2_IDX][6:0])) ^ cfg_q[INTMAP2_IDX][7];

      if (wr_done) begin
        if (addr_q inside {[8'h20:8'h2E]}) cfg_q[addr_q[3:0]] <= byte_in;
        if (addr_q == 8'h1F && byte_in == 8'h52) soft_arm_q <= 1'b1;
      end
      if (rd_done && rd_addr_q == 8'h15) dr_q <= 1'b0;
      if (rd_done && rd_addr_q == 8'h0B) begin
        act_q   <= 1'b0;
        inact_q <= 1'b0;
      end

      // Data arriving mid-transaction waits for CSN rise so bursts stay coherent.
      if (csn_rise && pend_v_q) begin
        meas_q   <= pend_q;
        dr_q     <= 1'b1;
        pend_v_q <= 1'b0;
      end
      if (i_meas_valid) begin
        if (csn_q[1]) begin
          meas_q   <= i_meas_data;
          dr_q     <= 1'b1;
          pend_v_q <= 1'b0;
        end else begin
          pend_q   <= i_meas_data;
          pend_v_q <= 1'b1;
        end
      end
      if (i_act_pulse)   act_q   <= 1'b1;
      if (i_inact_pulse) inact_q <= 1'b1;

      if (csn_rise) soft_arm_q <= 1'b0;
      if (csn_rise && soft_arm_q) begin
        for (int i = 0; i < 15; i++) cfg_q[i] <= (i == FILTER_IDX) ? 8'h13 : 8'h00;
        meas_q   <= 64'd0;
        pend_v_q <= 1'b0;
        dr_q     <= 1'b0;
        act_q    <= 1'b0;
        inact_q  <= 1'b0;
      end
    end
  end

  assign eo_cipo_o       = cipo_q;
  assign eo_int1         = int1_q;
  assign eo_int2         = int2_q;
  assign o_reg_power_ctl = cfg_q[POWER_IDX];
  assign o_transact_done = done_q;
  assign o_soft_reset    = soft_q;

endmodule

// File: tb/tb_adxl362_spi_responder.sv
module tb_adxl362_spi_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ei_sck = 1'b0, ei_csn = 1'b1, ei_copi = 1'b0;
  logic        eo_cipo_o, eo_cipo_t, eo_int1, eo_int2;
  logic [63:0] i_meas_data = 64'd0;
  logic        i_meas_valid = 1'b0, i_act_pulse = 1'b0, i_inact_pulse = 1'b0;
  logic [7:0]  o_reg_power_ctl;
  logic        o_transact_done, o_soft_reset;

  always #5 clk = ~clk;

  adxl362_spi_responder dut (
    .i_clk_20mhz     (clk),
    .i_rst_20mhz_n   (rst_n),
    .ei_sck          (ei_sck),
    .ei_csn          (ei_csn),
    .ei_copi         (ei_copi),
    .eo_cipo_o       (eo_cipo_o),
    .eo_cipo_t       (eo_cipo_t),
    .eo_int1         (eo_int1),
    .eo_int2         (eo_int2),
    .i_meas_data     (i_meas_data),
    .i_meas_valid    (i_meas_valid),
    .i_act_pulse     (i_act_pulse),
    .i_inact_pulse   (i_inact_pulse),
    .o_reg_power_ctl (o_reg_power_ctl),
    .o_transact_done (o_transact_done),
    .o_soft_reset    (o_soft_reset)
  );

  int n_vec = 0;
  int n_miss = 0;
  int done_cnt = 0;
  int soft_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_buf[16];
  logic [7:0] rx_buf[16];
  logic       t_buf[16];

  always @(negedge clk) begin
    if (o_transact_done) done_cnt++;
    if (o_soft_reset) soft_cnt++;
  end

  // SCK = clk/8: 4 clocks low (COPI set), 4 clocks high; CIPO sampled just before the fall.
  task automatic xfer(input int nbytes, input int extra_bits);
    int nb;
    ei_csn = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 0; b < nbytes + ((extra_bits > 0) ? 1 : 0); b++) begin
      nb = (b == nbytes) ? extra_bits : 8;
      rx_buf[b] = 8'h00;
      for (int k = 0; k < nb; k++) begin
        ei_copi = tx_buf[b][7-k];
        repeat (4) @(negedge clk);
        ei_sck = 1'b1;
        repeat (4) @(negedge clk);
        rx_buf[b][7-k] = eo_cipo_o;
        if (k == 0) t_buf[b] = eo_cipo_t;
        ei_sck = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    ei_csn = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic rd(input logic [7:0] addr, input int n);
    tx_buf[0] = 8'h0B;
    tx_buf[1] = addr;
    for (int i = 2; i < 16; i++) tx_buf[i] = 8'h00;
    xfer(n + 2, 0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    tx_buf[0] = 8'h0A;
    tx_buf[1] = addr;
    tx_buf[2] = data;
    xfer(3, 0);
  endtask

  task automatic pulse_meas(input logic [63:0] d);
    i_meas_data  = d;
    i_meas_valid = 1'b1;
    @(negedge clk);
    i_meas_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++; if (eo_cipo_t !== 1'b1) begin n_miss++; $display("FAIL reset_cipo_t got %b want 1", eo_cipo_t); end
    n_vec++; if (eo_cipo_o !== 1'b0) begin n_miss++; $display("FAIL reset_cipo_o got %b want 0", eo_cipo_o); end
    n_vec++; if (eo_int1 !== 1'b0) begin n_miss++; $display("FAIL reset_int1 got %b want 0", eo_int1); end
    n_vec++; if (eo_int2 !== 1'b0) begin n_miss++; $display("FAIL reset_int2 got %b want 0", eo_int2); end
    n_vec++; if (o_reg_power_ctl !== 8'h00) begin n_miss++; $display("FAIL reset_power got %02h want 00", o_reg_power_ctl); end
    n_vec++; if (o_transact_done !== 1'b0) begin n_miss++; $display("FAIL reset_done got %b want 0", o_transact_done); end
    n_vec++; if (o_soft_reset !== 1'b0) begin n_miss++; $display("FAIL reset_soft got %b want 0", o_soft_reset); end
  endtask

  task automatic test_id_read();
    logic [7:0] e;
    int d0;
    d0 = done_cnt;
    exp_q.push_back(8'hAD); exp_q.push_back(8'h1D); exp_q.push_back(8'hF2); exp_q.push_back(8'h01);
    rd(8'h00, 4);
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_vec++; if (rx_buf[k+2] !== e) begin n_miss++; $display("FAIL id_read byte %0d got %02h want %02h", k, rx_buf[k+2], e); end
      n_vec++; if (t_buf[k+2] !== 1'b0) begin n_miss++; $display("FAIL id_read_tz data %0d got %b want 0", k, t_buf[k+2]); end
    end
    for (int k = 0; k < 2; k++) begin
      n_vec++; if (t_buf[k] !== 1'b1) begin n_miss++; $display("FAIL id_read_tz hdr %0d got %b want 1", k, t_buf[k]); end
    end
    n_vec++; if (eo_cipo_t !== 1'b1) begin n_miss++; $display("FAIL id_read_tz idle got %b want 1", eo_cipo_t); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_miss++; $display("FAIL id_read_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_config_write();
    logic [7:0] e;
    wr(8'h2D, 8'h02);
    n_vec++; if (o_reg_power_ctl !== 8'h02) begin n_miss++; $display("FAIL cfg_power got %02h want 02", o_reg_power_ctl); end
    exp_q.push_back(8'h13); exp_q.push_back(8'h02);
    rd(8'h2C, 2);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      n_vec++; if (rx_buf[k+2] !== e) begin n_miss++; $display("FAIL cfg_readback byte %0d got %02h want %02h", k, rx_buf[k+2], e); end
    end
  endtask

  task automatic test_meas_burst();
    logic [7:0] e;
    pulse_meas(64'h0102030405060708);
    exp_q.push_back(8'h01);
    rd(8'h0B, 1);
    e = exp_q.pop_front();
    n_vec++; if (rx_buf[2] !== e) begin n_miss++; $display("FAIL meas_status_before got %02h want %02h", rx_buf[2], e); end
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(k + 1));
    rd(8'h0E, 8);
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      n_vec++; if (rx_buf[k+2] !== e) begin n_miss++; $display("FAIL meas_burst byte %0d got %02h want %02h", k, rx_buf[k+2], e); end
    end
    exp_q.push_back(8'h00);
    rd(8'h0B, 1);
    e = exp_q.pop_front();
    n_vec++; if (rx_buf[2] !== e) begin n_miss++; $display("FAIL meas_status_after got %02h want %02h", rx_buf[2], e); end
  endtask

  task automatic test_coherency();
    logic [7:0] e;
    logic [63:0] nd;
    nd = 64'hFFEEDDCCBBAA9988;
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(k + 1));
    fork
      rd(8'h0E, 8);
      begin
        repeat (200) @(negedge clk);
        pulse_meas(nd);
      end
    join
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      n_vec++; if (rx_buf[k+2] !== e) begin n_miss++; $display("FAIL coherent_old byte %0d got %02h want %02h", k, rx_buf[k+2], e); end
    end
    exp_q.push_back(8'h01);
    rd(8'h0B, 1);
    e = exp_q.pop_front();
    n_vec++; if (rx_buf[2] !== e) begin n_miss++; $display("FAIL coherent_status got %02h want %02h", rx_buf[2], e); end
    for (int k = 0; k < 8; k++) exp_q.push_back(nd[63-8*k -: 8]);
    rd(8'h0E, 8);
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      n_vec++; if (rx_buf[k+2] !== e) begin n_miss++; $display("FAIL coherent_new byte %0d got %02h want %02h", k, rx_buf[k+2], e); end
    end
  endtask

  task automatic test_interrupts();
    logic [7:0] e;
    wr(8'h2A, 8'h01);
    n_vec++; if (eo_int1 !== 1'b0) begin n_miss++; $display("FAIL int1_idle got %b want 0", eo_int1); end
    pulse_meas(64'h1111111111111111);
    repeat (4) @(negedge clk);
    n_vec++; if (eo_int1 !== 1'b1) begin n_miss++; $display("FAIL int1_dr got %b want 1", eo_int1); end
    wr(8'h2B, 8'h90);
    n_vec++; if (eo_int2 !== 1'b1) begin n_miss++; $display("FAIL int2_inverted got %b want 1", eo_int2); end
    i_act_pulse = 1'b1;
    @(negedge clk);
    i_act_pulse = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++; if (eo_int2 !== 1'b0) begin n_miss++; $display("FAIL int2_act got %b want 0", eo_int2); end
    exp_q.push_back(8'h11);
    rd(8'h0B, 1);
    e = exp_q.pop_front();
    n_vec++; if (rx_buf[2] !== e) begin n_miss++; $display("FAIL int_status got %02h want %02h", rx_buf[2], e); end
    n_vec++; if (eo_int2 !== 1'b1) begin n_miss++; $display("FAIL int2_cleared got %b want 1", eo_int2); end
    n_vec++; if (eo_int1 !== 1'b1) begin n_miss++; $display("FAIL int1_held got %b want 1", eo_int1); end
  endtask

  task automatic test_soft_reset_abort();
    logic [7:0] e;
    int d0, s0;
    d0 = done_cnt;
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h2D; tx_buf[2] = 8'hFF;
    xfer(2, 5);
    n_vec++; if (o_reg_power_ctl !== 8'h02) begin n_miss++; $display("FAIL abort_power got %02h want 02", o_reg_power_ctl); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_miss++; $display("FAIL abort_done got %0d want 1", done_cnt - d0); end
    s0 = soft_cnt;
    wr(8'h1F, 8'h53);
    n_vec++; if (soft_cnt - s0 !== 0) begin n_miss++; $display("FAIL soft_wrong_key got %0d want 0", soft_cnt - s0); end
    n_vec++; if (o_reg_power_ctl !== 8'h02) begin n_miss++; $display("FAIL soft_wrong_key_power got %02h want 02", o_reg_power_ctl); end
    d0 = done_cnt;
    wr(8'h1F, 8'h52);
    n_vec++; if (soft_cnt - s0 !== 1) begin n_miss++; $display("FAIL soft_pulse got %0d want 1", soft_cnt - s0); end
    n_vec++; if (done_cnt - d0 !== 1) begin n_miss++; $display("FAIL soft_done got %0d want 1", done_cnt - d0); end
    n_vec++; if (o_reg_power_ctl !== 8'h00) begin n_miss++; $display("FAIL soft_power got %02h want 00", o_reg_power_ctl); end
    n_vec++; if (eo_int1 !== 1'b0 || eo_int2 !== 1'b0) begin n_miss++; $display("FAIL soft_ints got %b%b want 00", eo_int1, eo_int2); end
    exp_q.push_back(8'h13); exp_q.push_back(8'h00);
    rd(8'h2C, 2);
    for (int k = 0; k < 2; k++) begin
      e = exp_q.pop_front();
      n_vec++; if (rx_buf[k+2] !== e) begin n_miss++; $display("FAIL soft_cfg byte %0d got %02h want %02h", k, rx_buf[k+2], e); end
    end
    exp_q.push_back(8'h00);
    rd(8'h0B, 1);
    e = exp_q.pop_front();
    n_vec++; if (rx_buf[2] !== e) begin n_miss++; $display("FAIL soft_status got %02h want %02h", rx_buf[2], e); end
    exp_q.push_back(8'h00);
    rd(8'h0E, 1);
    e = exp_q.pop_front();
    n_vec++; if (rx_buf[2] !== e) begin n_miss++; $display("FAIL soft_shadow got %02h want %02h", rx_buf[2], e); end
  endtask

  task automatic test_reset_midread();
    logic [7:0] e;
    wr(8'h2D, 8'h02);
    n_vec++; if (o_reg_power_ctl !== 8'h02) begin n_miss++; $display("FAIL midrst_pre_power got %02h want 02", o_reg_power_ctl); end
    fork
      rd(8'h00, 4);
      begin
        repeat (150) @(negedge clk);
        n_vec++; if (eo_cipo_t !== 1'b0) begin n_miss++; $display("FAIL midrst_driving got %b want 0", eo_cipo_t); end
        rst_n = 1'b0;
        #1;
        n_vec++; if (eo_cipo_t !== 1'b1) begin n_miss++; $display("FAIL midrst_tz got %b want 1", eo_cipo_t); end
        n_vec++; if (o_reg_power_ctl !== 8'h00) begin n_miss++; $display("FAIL midrst_power got %02h want 00", o_reg_power_ctl); end
      end
    join
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(8'hAD);
    rd(8'h00, 1);
    e = exp_q.pop_front();
    n_vec++; if (rx_buf[2] !== e) begin n_miss++; $display("FAIL midrst_recover got %02h want %02h", rx_buf[2], e); end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    test_id_read();
    test_config_write();
    test_meas_burst();
    test_coherency();
    test_interrupts();
    test_soft_reset_abort();
    test_reset_midread();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
